riscv_alu_issue: RTL and testbench
==================================

Name: riscv_alu_issue

Overview:
Issue and write-back stage that sits directly upstream of the integer ALU (RV32I + optional M).
- Accepts one fetched instruction word per valid/ready handshake.
- Decodes OP and OP-IMM formats and reads operands from an internal 32x32 register file.
- Drives the ALU operand and opcode inputs, then holds them stable while the ALU signals wait.
- Writes the ALU result to rd and reports retirement; single instruction in flight, strictly in order.

Parameters:
WAIT_LIMIT, 64, maximum EXEC cycles before the stall watchdog fires (must exceed worst-case mul/div latency of 34).
CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
inst_valid  in  1  fetch presents an instruction
inst_data  in  32  instruction word
inst_ready  out  1  stage can accept an instruction this cycle
alu_enabled  out  1  ALU enable; high only in EXEC
alu_is_op  out  1  opcode is OP (0110011)
alu_is_op_imm  out  1  opcode is OP-IMM (0010011)
alu_funct3  out  3  inst[14:12]
alu_funct7  out  7  inst[31:25]
alu_rs1  out  32  register-file value of rs1
alu_rs2  out  32  register-file value of rs2
alu_imm  out  32  sign-extended I-immediate inst[31:20]
alu_rd  in  32  ALU result
alu_wait  in  1  ALU needs further cycles
retire_valid  out  1  one-cycle pulse: instruction completed
retire_rd  out  5  destination of the retired instruction
retire_value  out  32  value written (0 if none)
retire_illegal  out  1  retired instruction was not OP/OP-IMM
stall_error  out  1  sticky: watchdog expired
dbg_addr  in  5  debug read address
dbg_data  out  32  debug read data, combinational; x0 reads 0

Behaviour:
- Reset (async, reset_n low): state IDLE; all regfile entries 0; inst_ready=1 after reset; alu_enabled=0; retire_valid=0; retire_rd=0; retire_value=0; retire_illegal=0; stall_error=0; counter=0; issue register 0.
- FSM states: IDLE, EXEC, HALT.
- IDLE
  - inst_ready=1.
  - On inst_valid: latch inst_data into the issue register and go to EXEC.
- EXEC
  - alu_enabled=1. All alu_* outputs are derived from the issue register only, so they are stable for the whole of EXEC.
  - alu_rs1/alu_rs2 are read combinationally from the regfile using issue rs1/rs2.
  - Completion cycle: alu_wait=0, or the opcode is illegal.
    - Write alu_rd to regfile[rd] if legal and rd!=0.
    - Register retire_* so retire_valid is high on the next cycle, for exactly one cycle.
  - Back-to-back issue:
    - inst_ready=1 during the completion cycle, so a new instruction may be latched the same edge; the next instruction enters EXEC with no bubble.
    - Its operand read occurs after the write edge, so a RAW dependency reads the new value. No bypass is needed.
  - inst_ready=0 while alu_wait=1.
- Latency
  - Simple ALU op: accept edge N, complete in cycle N+1, retire_valid in cycle N+2.
  - Multi-cycle op: completes in the first EXEC cycle with alu_wait=0.
- Illegal opcode: complete in 1 EXEC cycle, no regfile write, retire_illegal=1, retire_value=0.
- x0
  - Never written.
  - Reads return 0.
  - retire_rd still reports the encoded rd; retire_value reports alu_rd.
- Watchdog
  - The counter increments each EXEC cycle with alu_wait=1 and clears on completion.
  - When the count reaches WAIT_LIMIT: set stall_error, go to HALT.
  - HALT: inst_ready=0, alu_enabled=0; exits only on reset.
- Reset asserted mid-EXEC: the instruction is abandoned with no write and no retire pulse. The ALU, on the same reset, also clears.
- inst_data is ignored whenever inst_ready=0.

Decomposition:
- Shared package: opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011; state encoding; instruction field slice positions (rd 11:7, rs1 19:15, rs2 24:20, funct3, funct7, imm).
- One sub-module: riscv_regfile.
  - 2 combinational read ports plus the debug read port, 1 synchronous write port.
  - x0 hardwired to 0; asynchronous active-low clear.
- The FSM, issue register, decode, watchdog and retire registers stay in riscv_alu_issue.

Test Plan:
- addi x1,x0,5 then addi x2,x1,-7 back-to-back -> two retire pulses on consecutive cycles; x1=5, x2=0xFFFFFFFE; inst_ready never drops.
- add x3,x1,x1 with the ALU model holding alu_wait=1 for 33 cycles (mul) -> inst_ready=0 and alu_* stable throughout; retire with x3=model result; stall_error=0.
- addi x0,x0,9 -> retire_valid=1, retire_rd=0; dbg_addr=0 reads 0.
- Instruction 0x00000073 (SYSTEM) -> retire_illegal=1, no regfile change, one EXEC cycle.
- ALU model holds alu_wait=1 indefinitely -> stall_error=1 after 64 EXEC cycles; HALT; inst_ready stays 0 until reset_n pulse, after which everything clears.
- reset_n asserted on the 3rd wait cycle of a div -> no retire pulse, rd unchanged (0); IDLE with inst_ready=1 after release.

Source files
------------

// File: rtl/riscv_alu_issue_pkg.sv
// riscv_alu_issue_pkg: opcodes, FSM encoding and instruction field helpers for the ALU issue stage
package riscv_alu_issue_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  localparam int IMM_LSB = 20;
  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;
  function automatic logic [6:0] f_opc(input logic [31:0] i);
    return i[6:0];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[RD_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_rs1(input logic [31:0] i);
    return i[RS1_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] i);
    return i[RS2_LSB +: 5];
  endfunction
  function automatic logic [2:0] f_funct3(input logic [31:0] i);
    return i[F3_LSB +: 3];
  endfunction
  function automatic logic [6:0] f_funct7(input logic [31:0] i);
    return i[F7_LSB +: 7];
  endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[IMM_LSB +: 12]};
  endfunction
endpackage

// File: rtl/riscv_alu_issue_regfile.sv
// riscv_regfile: 32x32 register file, two operand reads plus debug read, one write, x0 hardwired to 0
module riscv_regfile (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] dbg_data
);
  logic [31:0] regs [32];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && waddr != 5'd0)
      regs[waddr] <= wdata;
  assign rdata1   = raddr1   == 5'd0 ? '0 : regs[raddr1];
  assign rdata2   = raddr2   == 5'd0 ? '0 : regs[raddr2];
  assign dbg_data = dbg_addr == 5'd0 ? '0 : regs[dbg_addr];
endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: single-in-flight issue/write-back stage feeding an RV32I(+M) ALU, with stall watchdog
module riscv_alu_issue
  import riscv_alu_issue_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  output logic        alu_enabled,
  output logic        alu_is_op,
  output logic        alu_is_op_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_rd,
  input  logic        alu_wait,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_value,
  output logic        retire_illegal,
  output logic        stall_error,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  state_t state_q, state_d;
  logic [31:0] issue_q;
  logic [CNT_W-1:0] cnt_q;
  logic legal, done, timeout;
  assign alu_is_op     = f_opc(issue_q) == OPC_OP;
  assign alu_is_op_imm = f_opc(issue_q) == OPC_OP_IMM;
  assign alu_funct3    = f_funct3(issue_q);
  assign alu_funct7    = f_funct7(issue_q);
  assign alu_imm       = f_imm(issue_q);
  assign legal   = alu_is_op || alu_is_op_imm;
  // illegal opcodes never wait on the ALU
  assign done    = state_q == EXEC && (!alu_wait || !legal);
  assign timeout = state_q == EXEC && !done && cnt_q == CNT_W'(WAIT_LIMIT - 1);
  riscv_regfile u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (done && legal),
    .waddr    (f_rd(issue_q)),
    .wdata    (alu_rd),
    .raddr1   (f_rs1(issue_q)),
    .raddr2   (f_rs2(issue_q)),
    .dbg_addr (dbg_addr),
    .rdata1   (alu_rs1),
    .rdata2   (alu_rs2),
    .dbg_data (dbg_data)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = inst_valid ? EXEC : IDLE;
      EXEC:    state_d = done ? (inst_valid ? EXEC : IDLE) : (timeout ? HALT : EXEC);
      default: state_d = HALT;
    endcase
  end
  always_comb begin
    inst_ready  = state_q == IDLE || done;
    alu_enabled = state_q == EXEC;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      issue_q        <= '0;
      cnt_q          <= '0;
      retire_valid   <= 1'b0;
      retire_rd      <= '0;
      retire_value   <= '0;
      retire_illegal <= 1'b0;
      stall_error    <= 1'b0;
    end else begin
      if (inst_ready && inst_valid) issue_q <= inst_data;
      cnt_q        <= (state_q == EXEC && !done) ? cnt_q + 1'b1 : '0;
      retire_valid <= done;
      stall_error  <= stall_error | timeout;
      if (done) begin
        retire_rd      <= f_rd(issue_q);
        retire_value   <= legal ? alu_rd : '0;
        retire_illegal <= !legal;
      end
    end
endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb_riscv_alu_issue: directed-vector bench with a small behavioural ALU that stretches ops via alu_wait
module tb_riscv_alu_issue;
  logic clock = 1'b0, reset_n = 1'b0;
  logic inst_valid = 1'b0;
  logic [31:0] inst_data = '0;
  logic inst_ready, alu_enabled, alu_is_op, alu_is_op_imm;
  logic [2:0] alu_funct3;
  logic [6:0] alu_funct7;
  logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_rd;
  logic alu_wait;
  logic retire_valid, retire_illegal, stall_error;
  logic [4:0] retire_rd;
  logic [31:0] retire_value;
  logic [4:0] dbg_addr = '0;
  logic [31:0] dbg_data;
  int checks = 0, errors = 0;
  int wait_n = 0;
  int exec_cnt;
  riscv_alu_issue dut (
    .clock(clock), .reset_n(reset_n), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_ready(inst_ready), .alu_enabled(alu_enabled), .alu_is_op(alu_is_op),
    .alu_is_op_imm(alu_is_op_imm), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_rd(alu_rd),
    .alu_wait(alu_wait), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_value(retire_value), .retire_illegal(retire_illegal),
    .stall_error(stall_error), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clock = ~clock;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) exec_cnt <= 0;
    else exec_cnt <= (alu_enabled && alu_wait) ? exec_cnt + 1 : 0;
  assign alu_wait = alu_enabled && exec_cnt < wait_n;
  assign alu_rd = alu_is_op_imm ? alu_rs1 + alu_imm :
                  alu_is_op ? (alu_funct7 == 7'd1 ? alu_rs1 * alu_rs2 : alu_rs1 + alu_rs2) : 32'd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
    dbg_addr = a;
    #1 check(tag, dbg_data, exp);
  endtask
  initial begin
    step(3);
    reset_n = 1'b1;
    check("rst_ready", inst_ready, 1);
    check("rst_en", alu_enabled, 0);
    check("rst_retire", retire_valid, 0);
    check("rst_stall", stall_error, 0);
    peek(5'd1, 0, "rst_x1");
    // addi x1,x0,5 ; addi x2,x1,-7 back to back
    inst_valid = 1'b1; inst_data = 32'h00500093;
    step();
    check("b2b_en", alu_enabled, 1);
    check("b2b_ready1", inst_ready, 1);
    inst_data = 32'hFF908113;
    step();
    check("b2b_ret1_v", retire_valid, 1);
    check("b2b_ret1_rd", retire_rd, 1);
    check("b2b_ret1_val", retire_value, 5);
    check("b2b_ready2", inst_ready, 1);
    check("b2b_raw_rs1", alu_rs1, 5);
    inst_valid = 1'b0;
    step();
    check("b2b_ret2_v", retire_valid, 1);
    check("b2b_ret2_rd", retire_rd, 2);
    check("b2b_ret2_val", retire_value, 32'hFFFFFFFE);
    step();
    check("b2b_ret_pulse", retire_valid, 0);
    peek(5'd1, 5, "x1");
    peek(5'd2, 32'hFFFFFFFE, "x2");
    // add x3,x1,x1 with 33 ALU wait cycles
    wait_n = 33;
    inst_valid = 1'b1; inst_data = 32'h001081B3;
    step();
    inst_valid = 1'b0; inst_data = 32'h00000073;
    for (int i = 0; i < 33; i++) begin
      check("mul_ready", inst_ready, 0);
      check("mul_rs1", alu_rs1, 5);
      check("mul_rs2", alu_rs2, 5);
      check("mul_isop", alu_is_op, 1);
      step();
    end
    check("mul_done_ready", inst_ready, 1);
    step();
    check("mul_ret_v", retire_valid, 1);
    check("mul_ret_rd", retire_rd, 3);
    check("mul_ret_val", retire_value, 10);
    check("mul_stall", stall_error, 0);
    peek(5'd3, 10, "x3");
    // addi x0,x0,9
    wait_n = 0;
    inst_valid = 1'b1; inst_data = 32'h00900013;
    step();
    inst_valid = 1'b0;
    step();
    check("x0_ret_v", retire_valid, 1);
    check("x0_ret_rd", retire_rd, 0);
    check("x0_ret_val", retire_value, 9);
    peek(5'd0, 0, "x0");
    // SYSTEM instruction is illegal and ignores alu_wait
    wait_n = 5;
    inst_valid = 1'b1; inst_data = 32'h00000073;
    step();
    inst_valid = 1'b0;
    check("ill_en", alu_enabled, 1);
    check("ill_ready", inst_ready, 1);
    step();
    check("ill_ret_v", retire_valid, 1);
    check("ill_flag", retire_illegal, 1);
    check("ill_val", retire_value, 0);
    check("ill_one_cycle", alu_enabled, 0);
    peek(5'd1, 5, "ill_x1");
    // hung ALU triggers watchdog
    wait_n = 1000;
    inst_valid = 1'b1; inst_data = 32'h00108233;
    step();
    inst_valid = 1'b0;
    step(63);
    check("wd_pre_stall", stall_error, 0);
    check("wd_pre_en", alu_enabled, 1);
    step();
    check("wd_stall", stall_error, 1);
    check("wd_halt_en", alu_enabled, 0);
    inst_valid = 1'b1; inst_data = 32'h00500093;
    for (int i = 0; i < 4; i++) begin
      check("halt_ready", inst_ready, 0);
      check("halt_retire", retire_valid, 0);
      step();
    end
    inst_valid = 1'b0;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    check("wd_rst_stall", stall_error, 0);
    check("wd_rst_ready", inst_ready, 1);
    peek(5'd1, 0, "wd_rst_x1");
    // reset on 3rd wait cycle of a div
    inst_valid = 1'b1; inst_data = 32'h0210C2B3;
    step();
    inst_valid = 1'b0;
    step(2);
    check("div_en", alu_enabled, 1);
    reset_n = 1'b0;
    wait_n = 0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("div_no_retire", retire_valid, 0);
      check("div_ready", inst_ready, 1);
      step();
    end
    peek(5'd5, 0, "div_x5");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
